u_d_sweep_ctrl: RTL and testbench

Sequencer for the 8-bit up/down load counter. It turns the counter into a programmable triangle sweep: lo → hi → lo, repeated N passes, then it freezes the counter. It drives the counter's load, u_d and data pins and watches its count bus. Between sweeps it holds the counter value by self-reloading it, because the counter advances on every clock.

---
 rtl/u_d_sweep_ctrl.sv | 144 ++++++++++++++
 tb/tb_u_d_sweep_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/u_d_sweep_ctrl.sv
// rtl/u_d_sweep_ctrl.sv - triangle sweep sequencer for an 8-bit up/down load counter
module u_d_sweep_ctrl #(
  parameter int W  = 8,
  parameter int PW = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic [W-1:0]  lo_i,
  input  logic [W-1:0]  hi_i,
  input  logic [PW-1:0] passes_i,
  input  logic [W-1:0]  ctr_count_i,
  output logic          ctr_load_o,
  output logic          ctr_u_d_o,
  output logic [W-1:0]  ctr_data_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          aborted_o,
  output logic          err_o,
  output logic [PW-1:0] pass_idx_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_UP   = 3'd2,
    S_DOWN = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  lo_q, lo_d;
  logic [W-1:0]  hi_q, hi_d;
  logic [PW-1:0] passes_q, passes_d;
  logic [PW-1:0] pass_idx_q, pass_idx_d;
  logic          err_q, err_d;
  logic          aborted_q, aborted_d;

  // State, latched sweep configuration, pass counter and status flags.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      lo_q       <= '0;
      hi_q       <= '0;
      passes_q   <= '0;
      pass_idx_q <= '0;
      err_q      <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      passes_q   <= passes_d;
      pass_idx_q <= pass_idx_d;
      err_q      <= err_d;
      aborted_q  <= aborted_d;
    end
  end

  // Next state and counter drive; the default self-reloads the counter so it holds.
  always_comb begin
    state_d    = state_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    passes_d   = passes_q;
    pass_idx_d = pass_idx_q;
    err_d      = 1'b0;
    aborted_d  = aborted_q;
    ctr_load_o = 1'b1;
    ctr_u_d_o  = 1'b0;
    ctr_data_o = ctr_count_i;
    done_o     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (lo_i >= hi_i) begin
            err_d = 1'b1;
          end else if (passes_i == '0) begin
            aborted_d = 1'b0;
            state_d   = S_DONE;
          end else begin
            lo_d       = lo_i;
            hi_d       = hi_i;
            passes_d   = passes_i;
            pass_idx_d = '0;
            aborted_d  = 1'b0;
            state_d    = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        ctr_data_o = lo_q;
        state_d    = S_UP;
      end
      S_UP: begin
        if (abort_i) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else begin
          ctr_load_o = 1'b0;
          if (ctr_count_i != hi_q) begin
            ctr_u_d_o = 1'b1;
          end else begin
            state_d = S_DOWN;
          end
        end
      end
      S_DOWN: begin
        if (abort_i) begin
          aborted_d = 1'b1;
          state_d   = S_DONE;
        end else if (ctr_count_i != lo_q) begin
          ctr_load_o = 1'b0;
        end else if (pass_idx_q < (passes_q - PW'(1))) begin
          // Turn around at the floor without a dead cycle.
          ctr_load_o = 1'b0;
          ctr_u_d_o  = 1'b1;
          pass_idx_d = pass_idx_q + PW'(1);
          state_d    = S_UP;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Status decodes.
  always_comb begin
    busy_o     = (state_q == S_LOAD) || (state_q == S_UP) || (state_q == S_DOWN);
    aborted_o  = aborted_q;
    err_o      = err_q;
    pass_idx_o = pass_idx_q;
  end

endmodule

// File: tb/tb_u_d_sweep_ctrl.sv
// tb/tb_u_d_sweep_ctrl.sv - self-checking bench for u_d_sweep_ctrl with an attached counter model
module tb_u_d_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] lo = '0;
  logic [7:0] hi = '0;
  logic [3:0] passes = '0;
  logic [7:0] cnt = 8'd77;
  logic       ctr_load, ctr_u_d, busy, done, aborted, err;
  logic [7:0] ctr_data;
  logic [3:0] pass_idx;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  // Attached up/down load counter: load wins, else count by direction.
  always_ff @(posedge clk) begin
    if (ctr_load) cnt <= ctr_data;
    else if (ctr_u_d) cnt <= cnt + 8'd1;
    else cnt <= cnt - 8'd1;
  end

  u_d_sweep_ctrl #(.W(8), .PW(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .lo_i(lo), .hi_i(hi), .passes_i(passes), .ctr_count_i(cnt),
    .ctr_load_o(ctr_load), .ctr_u_d_o(ctr_u_d), .ctr_data_o(ctr_data),
    .busy_o(busy), .done_o(done), .aborted_o(aborted), .err_o(err),
    .pass_idx_o(pass_idx)
  );

  task automatic test_reset();
    repeat (2) @(negedge clk);
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got %b want 0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got %b want 0", done); end
    nvec++; if (err !== 1'b0 || aborted !== 1'b0) begin nerr++; $display("FAIL reset_flags err=%b aborted=%b want 0 0", err, aborted); end
    nvec++; if (ctr_load !== 1'b1 || ctr_u_d !== 1'b0) begin nerr++; $display("FAIL reset_ctrl load=%b u_d=%b want 1 0", ctr_load, ctr_u_d); end
    nvec++; if (ctr_data !== 8'd77 || cnt !== 8'd77) begin nerr++; $display("FAIL reset_hold data=%0d cnt=%0d want 77", ctr_data, cnt); end
    nvec++; if (pass_idx !== 4'd0) begin nerr++; $display("FAIL reset_pass_idx got %0d want 0", pass_idx); end
    rst_n = 1'b1;
    @(negedge clk);
    nvec++; if (cnt !== 8'd77) begin nerr++; $display("FAIL reset_release_hold cnt=%0d want 77", cnt); end
  endtask

  // Full sweep; abort_at=k raises abort in the cycle after edge k (0 = no abort).
  task automatic run_sweep(input int l, input int h, input int p, input int abort_at,
                           input int hold, input bit start_in_done);
    int exp_q[$];
    int d, last, pi, fin;
    d = h - l;
    exp_q.push_back(l);
    for (int ps = 0; ps < p; ps++) begin
      for (int v = l + 1; v <= h; v++) exp_q.push_back(v);
      for (int v = h - 1; v >= l; v--) exp_q.push_back(v);
    end
    last = (abort_at != 0) ? abort_at : exp_q.size();
    @(negedge clk);
    lo = 8'(l); hi = 8'(h); passes = 4'(p); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nvec++; if (busy !== 1'b1 || ctr_load !== 1'b1 || ctr_data !== 8'(l)) begin
      nerr++; $display("FAIL sweep_load busy=%b load=%b data=%0d want 1 1 %0d", busy, ctr_load, ctr_data, l);
    end
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      pi = (k < 2) ? 0 : (k - 2) / (2 * d);
      nvec++; if (cnt !== 8'(exp_q[k-1]) || busy !== 1'b1 || done !== 1'b0 || pass_idx !== 4'(pi)) begin
        nerr++; $display("FAIL sweep_edge%0d cnt=%0d busy=%b done=%b pidx=%0d want %0d 1 0 %0d",
                         k, cnt, busy, done, pass_idx, exp_q[k-1], pi);
      end
      if (k == abort_at) abort = 1'b1;
    end
    @(negedge clk);
    abort = 1'b0;
    fin = exp_q[last-1];
    pi = (last < 2) ? 0 : (last - 2) / (2 * d);
    nvec++; if (cnt !== 8'(fin) || done !== 1'b1 || busy !== 1'b0 || aborted !== (abort_at != 0) || pass_idx !== 4'(pi)) begin
      nerr++; $display("FAIL sweep_done cnt=%0d done=%b busy=%b aborted=%b pidx=%0d want %0d 1 0 %b %0d",
                       cnt, done, busy, aborted, pass_idx, fin, abort_at != 0, pi);
    end
    if (start_in_done) begin
      lo = 8'd3; hi = 8'd9; passes = 4'd1; start = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
    nvec++; if (done !== 1'b0 || busy !== 1'b0 || cnt !== 8'(fin)) begin
      nerr++; $display("FAIL sweep_after_done done=%b busy=%b cnt=%0d want 0 0 %0d", done, busy, cnt, fin);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      nvec++; if (cnt !== 8'(fin) || busy !== 1'b0 || done !== 1'b0) begin
        nerr++; $display("FAIL sweep_hold%0d cnt=%0d busy=%b done=%b want %0d 0 0", i, cnt, busy, done, fin);
      end
    end
  endtask

  task automatic test_reject(input int l, input int h);
    logic [7:0] c0;
    @(negedge clk);
    c0 = cnt;
    lo = 8'(l); hi = 8'(h); passes = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nvec++; if (err !== 1'b1 || busy !== 1'b0 || cnt !== c0) begin
      nerr++; $display("FAIL reject_pulse err=%b busy=%b cnt=%0d want 1 0 %0d", err, busy, cnt, c0);
    end
    @(negedge clk);
    nvec++; if (err !== 1'b0 || busy !== 1'b0 || cnt !== c0) begin
      nerr++; $display("FAIL reject_after err=%b busy=%b cnt=%0d want 0 0 %0d", err, busy, cnt, c0);
    end
  endtask

  task automatic test_zero_passes();
    logic [7:0] c0;
    @(negedge clk);
    c0 = cnt;
    lo = 8'd40; hi = 8'd50; passes = 4'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nvec++; if (done !== 1'b1 || busy !== 1'b0 || aborted !== 1'b0 || ctr_load !== 1'b1 || cnt !== c0) begin
      nerr++; $display("FAIL zero_pass_done done=%b busy=%b aborted=%b load=%b cnt=%0d want 1 0 0 1 %0d",
                       done, busy, aborted, ctr_load, cnt, c0);
    end
    @(negedge clk);
    nvec++; if (done !== 1'b0 || busy !== 1'b0 || cnt !== c0) begin
      nerr++; $display("FAIL zero_pass_after done=%b busy=%b cnt=%0d want 0 0 %0d", done, busy, cnt, c0);
    end
  endtask

  task automatic test_reset_mid_down();
    bit seen_hi = 1'b0;
    bit found = 1'b0;
    @(negedge clk);
    lo = 8'd25; hi = 8'd40; passes = 4'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (cnt == 8'd40) seen_hi = 1'b1;
      if (seen_hi && cnt == 8'd30) found = 1'b1;
    end
    nvec++; if (!found) begin nerr++; $display("FAIL reset_mid_wait cnt=%0d want 30 in DOWN", cnt); end
    rst_n = 1'b0;
    #1;
    nvec++; if (busy !== 1'b0 || done !== 1'b0 || ctr_load !== 1'b1) begin
      nerr++; $display("FAIL reset_mid_async busy=%b done=%b load=%b want 0 0 1", busy, done, ctr_load);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      nvec++; if (cnt !== 8'd30 || done !== 1'b0 || busy !== 1'b0) begin
        nerr++; $display("FAIL reset_mid_hold%0d cnt=%0d done=%b busy=%b want 30 0 0", i, cnt, done, busy);
      end
    end
    run_sweep(25, 40, 1, 0, 2, 1'b0);
  endtask

  task automatic test_random();
    int l, d, p, ab;
    for (int n = 0; n < 8; n++) begin
      l  = $urandom_range(0, 230);
      d  = $urandom_range(1, 10);
      p  = $urandom_range(1, 3);
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 1 + 2 * p * d) : 0;
      run_sweep(l, l + d, p, ab, 2, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    run_sweep(10, 13, 2, 0, 20, 1'b0);
    run_sweep(20, 21, 1, 0, 3, 1'b0);
    test_reject(5, 5);
    test_reject(9, 4);
    run_sweep(0, 200, 1, 58, 3, 1'b1);
    test_zero_passes();
    test_reset_mid_down();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
